// File: rtl/cv32e40n_apu_responder.sv
// cv32e40n_apu_responder: APU-side responder model for the core's apu_* channel.
// Accepts up to DEPTH outstanding ops and returns each one LATENCY cycles after
// acceptance, in order, with a result from a small deterministic ALU.
// Ports:
//   clk_i, rst_i     clock, synchronous active-high reset
//   apu_operands_i   NARGS x 32 operands ([0]=a, [1]=b, [2]=c)
//   apu_op_i         op select, low 2 bits: ADD, SUB, XOR, MAC
//   apu_flags_i      downstream flags, unused
//   apu_req_i        request valid
//   apu_gnt_o        grant (accept = req & gnt)
//   apu_rvalid_o     one-cycle result valid per accepted op
//   apu_result_o     result, zero when not valid
//   apu_flags_o      [0]=zero, [1]=carry/borrow, rest zero

module cv32e40n_apu_responder #(
    parameter int NARGS    = 3,
    parameter int WOP      = 6,
    parameter int NDSFLAGS = 15,
    parameter int NUSFLAGS = 5,
    parameter int LATENCY  = 1,
    parameter int DEPTH    = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NARGS-1:0][31:0]    apu_operands_i,
    input  logic [WOP-1:0]            apu_op_i,
    input  logic [NDSFLAGS-1:0]       apu_flags_i,
    input  logic                      apu_req_i,
    output logic                      apu_gnt_o,
    output logic                      apu_rvalid_o,
    output logic [31:0]               apu_result_o,
    output logic [NUSFLAGS-1:0]       apu_flags_o
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [CW-1:0]       count_q, count_d;
    logic [LATENCY-1:0]  valid_q, valid_d;
    logic [31:0]         res_q [LATENCY];
    logic [31:0]         res_d [LATENCY];
    logic [NUSFLAGS-1:0] flg_q [LATENCY];
    logic [NUSFLAGS-1:0] flg_d [LATENCY];

    logic                accept;
    logic                retire;
    logic [31:0]         op_a, op_b, op_c;
    logic [32:0]         sum;
    logic [32:0]         dif;
    logic [31:0]         prod;
    logic [31:0]         alu_res;
    logic [NUSFLAGS-1:0] alu_flg;
    logic                unused_ok;

    assign unused_ok = ^{apu_flags_i, apu_op_i, apu_operands_i};

    assign op_a = apu_operands_i[0];
    assign op_b = apu_operands_i[1];

    generate
        if (NARGS > 2) begin : g_c
            assign op_c = apu_operands_i[2];
        end else begin : g_noc
            assign op_c = '0;
        end
    endgenerate

    // Grant looks only at the registered count, never at a same-cycle retire.
    assign apu_gnt_o = !rst_i && (count_q < DEPTH_C);
    assign accept    = apu_req_i && apu_gnt_o;
    assign retire    = valid_q[LATENCY-1];

    assign apu_rvalid_o = retire && !rst_i;
    assign apu_result_o = apu_rvalid_o ? res_q[LATENCY-1] : '0;
    assign apu_flags_o  = apu_rvalid_o ? flg_q[LATENCY-1] : '0;

    always_comb begin
        sum     = {1'b0, op_a} + {1'b0, op_b};
        dif     = {1'b0, op_a} - {1'b0, op_b};
        prod    = op_a * op_b;
        alu_res = '0;
        alu_flg = '0;
        unique case (apu_op_i[1:0])
            2'd0: begin
                alu_res    = sum[31:0];
                alu_flg[1] = sum[32];
            end
            2'd1: begin
                alu_res    = dif[31:0];
                // borrow out of the 33-bit difference is a<b unsigned
                alu_flg[1] = dif[32];
            end
            2'd2: alu_res = op_a ^ op_b;
            2'd3: alu_res = prod + op_c;
            default: alu_res = '0;
        endcase
        alu_flg[0] = (alu_res == '0);
    end

    always_comb begin
        valid_d    = '0;
        valid_d[0] = accept;
        res_d[0]   = alu_res;
        flg_d[0]   = alu_flg;
        for (int i = 1; i < LATENCY; i++) begin
            valid_d[i] = valid_q[i-1];
            res_d[i]   = res_q[i-1];
            flg_d[i]   = flg_q[i-1];
        end
    end

    always_comb begin
        count_d = count_q;
        unique case ({accept, retire})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
            valid_q <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                res_q[i] <= '0;
                flg_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            valid_q <= valid_d;
            for (int i = 0; i < LATENCY; i++) begin
                res_q[i] <= res_d[i];
                flg_q[i] <= flg_d[i];
            end
        end
    end

endmodule
